// File: rtl/iter_muldiv_unit.sv
`timescale 1ns/1ps
// iter_muldiv_unit: radix-2 iterative MUL/UMULH/UDIV/SDIV with start/busy/done handshake
module iter_muldiv_unit #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset_L,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [4:0]       Rd,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       RdOut,
    output logic             DivByZero
);
    localparam int CntW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;
    stateT            state, stateNext;
    logic [CntW-1:0]  count;
    logic [1:0]       opReg;
    logic [4:0]       rdReg;
    logic             negQuot;
    logic [WIDTH-1:0] divisor, hi, lo, hiNext, loNext, divHi, magA, magB, finalResult;
    logic [WIDTH:0]   mulSum, shifted;
    logic             fits, divZero, isSdiv;
    assign isSdiv  = Op == 2'b11;
    assign divZero = Op[1] && BusB == '0;
    assign magA    = isSdiv && BusA[WIDTH-1] ? -BusA : BusA;
    assign magB    = isSdiv && BusB[WIDTH-1] ? -BusB : BusB;
    // hi:lo is the product register for multiply, remainder:quotient for divide
    assign mulSum      = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
    assign shifted     = {hi, lo[WIDTH-1]};
    assign fits        = shifted >= {1'b0, divisor};
    assign divHi       = fits ? shifted[WIDTH-1:0] - divisor : shifted[WIDTH-1:0];
    assign hiNext      = opReg[1] ? divHi : mulSum[WIDTH:1];
    assign loNext      = opReg[1] ? {lo[WIDTH-2:0], fits} : {mulSum[0], lo[WIDTH-1:1]};
    assign finalResult = opReg == 2'b01 ? hiNext : (negQuot ? -loNext : loNext);
    assign Busy = state == CALC;
    assign Done = state == DONE;
    always_comb begin
        stateNext = IDLE;
        if (state == CALC)
            stateNext = count == '0 ? DONE : CALC;
        else if (Start)
            stateNext = divZero ? DONE : CALC;
    end
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state     <= IDLE;
            count     <= '0;
            opReg     <= '0;
            rdReg     <= '0;
            negQuot   <= 1'b0;
            divisor   <= '0;
            hi        <= '0;
            lo        <= '0;
            Result    <= '0;
            RdOut     <= '0;
            DivByZero <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == CALC) begin
                hi    <= hiNext;
                lo    <= loNext;
                count <= count - CntW'(1);
                if (count == '0) begin
                    Result    <= finalResult;
                    RdOut     <= rdReg;
                    DivByZero <= 1'b0;
                end
            end else if (Start) begin
                opReg   <= Op;
                rdReg   <= Rd;
                negQuot <= isSdiv && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
                divisor <= Op[1] ? magB : BusA;
                hi      <= '0;
                lo      <= Op[1] ? magA : BusB;
                count   <= CntW'(WIDTH - 1);
                if (divZero) begin
                    Result    <= '0;
                    RdOut     <= Rd;
                    DivByZero <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iter_muldiv_unit.sv
`timescale 1ns/1ps
// tb_iter_muldiv_unit: directed vectors against an arithmetic reference model with cycle-accurate handshake checks
module tb_iter_muldiv_unit;
    localparam int W = 64;
    logic         Clk = 1'b0;
    logic         Reset_L;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] BusA, BusB;
    logic [4:0]   Rd;
    logic         Busy, Done, DivByZero;
    logic [W-1:0] Result;
    logic [4:0]   RdOut;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic         active = 1'b0;
    int           accCyc = 0, doneCyc = 0;
    logic [W-1:0] eRes = '0, hRes = '0;
    logic [4:0]   eRd = '0, hRd = '0;
    logic         eDz = 1'b0, hDz = 1'b0;

    iter_muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset_L(Reset_L), .Start(Start), .Op(Op), .BusA(BusA), .BusB(BusB), .Rd(Rd),
        .Busy(Busy), .Done(Done), .Result(Result), .RdOut(RdOut), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [64:0] refModel(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  ma, mb, q;
        p  = {64'b0, a} * {64'b0, b};
        ma = (op == 2'b11 && a[63]) ? -a : a;
        mb = (op == 2'b11 && b[63]) ? -b : b;
        if (op[1] && b == 64'd0) return {1'b1, 64'd0};
        case (op)
            2'b00:   return {1'b0, p[63:0]};
            2'b01:   return {1'b0, p[127:64]};
            2'b10:   return {1'b0, a / b};
            default: begin
                q = ma / mb;
                return {1'b0, (a[63] ^ b[63]) ? -q : q};
            end
        endcase
    endfunction

    // Transaction-level model: an accepted request finishes WIDTH cycles later, or at once for divide-by-zero
    always @(posedge Clk or negedge Reset_L) begin : model
        int e;
        logic [64:0] r;
        if (!Reset_L) begin
            active <= 1'b0;
            hRes   <= '0;
            hRd    <= '0;
            hDz    <= 1'b0;
        end else begin
            e = cyc + 1;
            cyc <= e;
            if (Start && !(active && cyc >= accCyc && cyc < doneCyc)) begin
                r = refModel(Op, BusA, BusB);
                active  <= 1'b1;
                accCyc  <= e;
                doneCyc <= r[64] ? e : e + W;
                eRes    <= r[63:0];
                eRd     <= Rd;
                eDz     <= r[64];
                if (r[64]) begin
                    hRes <= '0;
                    hRd  <= Rd;
                    hDz  <= 1'b1;
                end
            end else if (active && e == doneCyc) begin
                hRes <= eRes;
                hRd  <= eRd;
                hDz  <= eDz;
            end
        end
    end

    always @(negedge Clk) begin
        if (!Reset_L) begin
            chk("rstBusy", 64'(Busy), 64'd0);
            chk("rstDone", 64'(Done), 64'd0);
            chk("rstResult", Result, 64'd0);
        end else begin
            chk("busy", 64'(Busy), 64'(active && cyc >= accCyc && cyc < doneCyc));
            chk("done", 64'(Done), 64'(active && cyc == doneCyc));
            chk("result", Result, hRes);
            chk("rdOut", 64'(RdOut), 64'(hRd));
            chk("divByZero", 64'(DivByZero), 64'(hDz));
        end
    end

    task automatic waitDone(output int n);
        n = 0;
        while (!Done && n < 200) begin
            @(posedge Clk);
            #1;
            n++;
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] expRes, input logic expDz, input int expLat);
        int lat;
        Op = op; BusA = a; BusB = b; Rd = rd; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        waitDone(lat);
        chk("latency", 64'(lat), 64'(expLat));
        chk("litResult", Result, expRes);
        chk("litRdOut", 64'(RdOut), 64'(rd));
        chk("litDivByZero", 64'(DivByZero), 64'(expDz));
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int n, stray;
        Reset_L = 1'b0; Start = 1'b0; Op = '0; BusA = '0; BusB = '0; Rd = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("resetResult", Result, 64'd0);
        chk("resetRdOut", 64'(RdOut), 64'd0);
        Reset_L = 1'b1;
        @(posedge Clk);
        #1;
        runOp(2'b00, 64'd7, 64'd6, 5'd5, 64'd42, 1'b0, 64);
        runOp(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'h1, 1'b0, 64);
        runOp(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64);
        runOp(2'b10, 64'd100, 64'd7, 5'd7, 64'd14, 1'b0, 64);
        runOp(2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd8, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 64);
        runOp(2'b11, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd9, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 64);
        runOp(2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd10, 64'd14, 1'b0, 64);
        runOp(2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'h8000_0000_0000_0000, 1'b0, 64);
        runOp(2'b01, 64'h1234_5678_9ABC_DEF0, 64'h1_0000, 5'd12, 64'h1234, 1'b0, 64);
        runOp(2'b10, 64'd55, 64'd0, 5'd13, 64'd0, 1'b1, 0);
        runOp(2'b11, 64'd5, 64'd0, 5'd14, 64'd0, 1'b1, 0);
        runOp(2'b00, 64'd55, 64'd0, 5'd15, 64'd0, 1'b0, 64);
        runOp(2'b10, 64'd3, 64'd10, 5'd16, 64'd0, 1'b0, 64);
        // Start during CALC must be ignored
        Op = 2'b10; BusA = 64'd100; BusB = 64'd7; Rd = 5'd3; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        Op = 2'b00; BusA = 64'd2; BusB = 64'd2; Rd = 5'd4; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        waitDone(n);
        chk("ignoredResult", Result, 64'd14);
        chk("ignoredRdOut", 64'(RdOut), 64'd3);
        @(posedge Clk);
        #1;
        // Back-to-back: Start held high through DONE
        Op = 2'b00; BusA = 64'd3; BusB = 64'd5; Rd = 5'd1; Start = 1'b1;
        @(posedge Clk);
        #1;
        Op = 2'b10; BusA = 64'd1000; BusB = 64'd10; Rd = 5'd2;
        waitDone(n);
        chk("b2bFirstResult", Result, 64'd15);
        chk("b2bFirstRdOut", 64'(RdOut), 64'd1);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        n = 1;
        while (!Done && n < 200) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("b2bGap", 64'(n), 64'd65);
        chk("b2bSecondResult", Result, 64'd100);
        chk("b2bSecondRdOut", 64'(RdOut), 64'd2);
        @(posedge Clk);
        #1;
        // Asynchronous reset mid-divide
        Op = 2'b10; BusA = 64'd999; BusB = 64'd9; Rd = 5'd20; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (30) @(posedge Clk);
        #1;
        chk("preResetBusy", 64'(Busy), 64'd1);
        Reset_L = 1'b0;
        #1;
        chk("asyncBusy", 64'(Busy), 64'd0);
        chk("asyncDone", 64'(Done), 64'd0);
        chk("asyncResult", Result, 64'd0);
        chk("asyncRdOut", 64'(RdOut), 64'd0);
        chk("asyncDivByZero", 64'(DivByZero), 64'd0);
        repeat (2) @(posedge Clk);
        #3;
        Reset_L = 1'b1;
        stray = 0;
        repeat (80) begin
            @(posedge Clk);
            #1;
            if (Done) stray++;
        end
        chk("noStrayDone", 64'(stray), 64'd0);
        runOp(2'b00, 64'd9, 64'd9, 5'd9, 64'd81, 1'b0, 64);
        repeat (3) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
